// File: rtl/mips_mux_pkg.sv
// Shared constants and helpers for the datapath select muxes (register-destination, ALU-source, writeback).
// Lane slicing is a macro because the lane width is a parameter of each user.
`ifndef MIPS_MUX_PKG_SV
`define MIPS_MUX_PKG_SV

`define MIPS_MUX_LANE(bus, k, w) bus[(k)*(w) +: (w)]

package mips_mux_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int REGADDR_W     = 5;

    // Smallest r with 2**r >= n; callers guarantee n >= 2, so the result is at least 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

`endif

// File: rtl/mux_skid_buf.sv
// One-entry skid register (payload = selected lane + sel); push/pop in the same cycle as the request.
// Only compiled when MUX_PIPE_SKID_EN is defined; flush empties the entry.
`ifdef MUX_PIPE_SKID_EN
module mux_skid_buf #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [PW-1:0] i_dat,
    output logic          o_vld,
    output logic [PW-1:0] o_dat
);

    logic          r_vld;
    logic [PW-1:0] r_dat;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_vld <= 1'b0;
        end else if (i_push) begin
            r_vld <= 1'b1;
        end else if (i_pop) begin
            r_vld <= 1'b0;
        end
    end

    // Payload is don't-care while empty, so it only needs a load enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dat <= '0;
        end else if (i_push && !i_flush) begin
            r_dat <= i_dat;
        end
    end

    assign o_vld = r_vld;
    assign o_dat = r_dat;

endmodule
`endif

// File: rtl/mux_pipe_nt1.sv
// N-lane registered select mux with valid/ready on both sides; 1-cycle latency, stall holds the output, flush kills it.
// MUX_PIPE_SKID_EN adds a 1-entry input skid so in_ready no longer depends on out_ready.
module mux_pipe_nt1
    import mips_mux_pkg::*;
#(
    parameter int  WIDTH = DEFAULT_WIDTH,
    parameter int  N     = 4,
    localparam int SEL_W = clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_sel_err;

    logic [WIDTH-1:0] w_lane_dat;
    logic             w_in_oor;
    logic             w_out_free;
    logic             w_accept;
    logic             w_load;
    logic [WIDTH-1:0] w_src_dat;
    logic             w_src_oor;

    // Out-of-range selects fall through to zero.
    always_comb begin
        w_lane_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(sel) == k) w_lane_dat = `MIPS_MUX_LANE(in_data, k, WIDTH);
        end
    end

    assign w_in_oor   = int'(sel) >= N;
    assign w_out_free = !r_out_valid || out_ready;

`ifdef MUX_PIPE_SKID_EN
    logic                   w_skid_vld;
    logic [WIDTH+SEL_W-1:0] w_skid_pay;
    logic [WIDTH-1:0]       w_skid_dat;
    logic [SEL_W-1:0]       w_skid_sel;

    assign in_ready = !w_skid_vld && !rst;
    assign w_accept = in_valid && in_ready;

    mux_skid_buf #(
        .PW (WIDTH + SEL_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_push  (w_accept && !w_out_free),
        .i_pop   (w_out_free),
        .i_dat   ({w_lane_dat, sel}),
        .o_vld   (w_skid_vld),
        .o_dat   (w_skid_pay)
    );

    assign w_skid_dat = w_skid_pay[WIDTH+SEL_W-1:SEL_W];
    assign w_skid_sel = w_skid_pay[SEL_W-1:0];

    // A held skid item always goes out before anything new; accept is impossible while it is held.
    assign w_load    = (w_skid_vld || w_accept) && w_out_free;
    assign w_src_dat = w_skid_vld ? w_skid_dat : w_lane_dat;
    assign w_src_oor = w_skid_vld ? (int'(w_skid_sel) >= N) : w_in_oor;
`else
    assign in_ready  = !rst && w_out_free;
    assign w_accept  = in_valid && in_ready;
    assign w_load    = w_accept;
    assign w_src_dat = w_lane_dat;
    assign w_src_oor = w_in_oor;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_sel_err   <= 1'b0;
        end else if (flush) begin
            // out_data keeps its old value; only the valid/err qualifiers drop.
            r_out_valid <= 1'b0;
            r_sel_err   <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= w_src_dat;
            r_out_valid <= 1'b1;
            r_sel_err   <= w_src_oor;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_sel_err   <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_mux_pipe_nt1.sv
// Directed bench for mux_pipe_nt1: a 4x32 instance for select/stall/flush/skid and a 5x5 instance for out-of-range selects.
`timescale 1ns/1ps
module tb_mux_pipe_nt1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 4 lanes x 32 bits
    logic [127:0] a_in_data;
    logic [1:0]   a_sel;
    logic         a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_sel_err;
    logic [31:0]  a_out_data;

    mux_pipe_nt1 #(.WIDTH(32), .N(4)) u_a (
        .clk       (clk),
        .rst       (rst),
        .in_data   (a_in_data),
        .sel       (a_sel),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .flush     (a_flush),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .sel_err   (a_sel_err)
    );

    // 5 lanes x 5 bits
    logic [24:0]  b_in_data;
    logic [2:0]   b_sel;
    logic         b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_sel_err;
    logic [4:0]   b_out_data;

    mux_pipe_nt1 #(.WIDTH(5), .N(5)) u_b (
        .clk       (clk),
        .rst       (rst),
        .in_data   (b_in_data),
        .sel       (b_sel),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .flush     (b_flush),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .sel_err   (b_sel_err)
    );

    localparam logic [127:0] LANES_A = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
    localparam logic [24:0]  LANES_B = {5'h14, 5'h13, 5'h12, 5'h11, 5'h10};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2000) @(posedge clk);
        bad++;
        $error("FAIL watchdog expired before test completion");
        $finish;
    end

    initial begin
        a_in_data = LANES_A; a_sel = 2'd0; a_in_valid = 1'b1; a_flush = 1'b0; a_out_ready = 1'b1;
        b_in_data = LANES_B; b_sel = 3'd0; b_in_valid = 1'b1; b_flush = 1'b0; b_out_ready = 1'b1;
        rst = 1'b1;
        #1;

        // Reset held two edges with in_valid asserted
        chk("rst_in_ready_a", a_in_ready, 1'b0);
        chk("rst_in_ready_b", b_in_ready, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_out_valid", a_out_valid, 1'b0);
            chk("rst_out_data", a_out_data, 32'h0);
            chk("rst_sel_err", a_sel_err, 1'b0);
            chk("rst_in_ready", a_in_ready, 1'b0);
            chk("rst_b_out_valid", b_out_valid, 1'b0);
        end
        rst = 1'b0;
        b_in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", a_in_ready, 1'b1);

        // Select sweep, back-to-back
        a_sel = 2'd0; step();
        chk("sweep0_data", a_out_data, 32'hA0);
        chk("sweep0_valid", a_out_valid, 1'b1);
        a_sel = 2'd1; step();
        chk("sweep1_data", a_out_data, 32'hB1);
        chk("sweep1_valid", a_out_valid, 1'b1);
        a_sel = 2'd2; step();
        chk("sweep2_data", a_out_data, 32'hC2);
        a_sel = 2'd3; step();
        chk("sweep3_data", a_out_data, 32'hD3);
        chk("sweep3_valid", a_out_valid, 1'b1);
        chk("sweep3_err", a_sel_err, 1'b0);

        // Stall: accept C2, then hold out_ready low while lanes change
        a_sel = 2'd2; step();
        chk("stall_load", a_out_data, 32'hC2);
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in_data = {4{32'h5A5A0000 | 32'(i)}};
            a_sel = 2'(i);
            #1;
`ifdef MUX_PIPE_SKID_EN
            chk("stall_in_ready_skid", a_in_ready, 1'b1);
`else
            chk("stall_in_ready", a_in_ready, 1'b0);
`endif
            step();
            chk("stall_data", a_out_data, 32'hC2);
            chk("stall_valid", a_out_valid, 1'b1);
        end
        a_in_data = LANES_A;
        a_out_ready = 1'b1;
        #1;
        chk("release_in_ready", a_in_ready, 1'b1);
        step();
        chk("release_consumed", a_out_valid, 1'b0);
        chk("release_data_kept", a_out_data, 32'hC2);

        // Flush kills a same-cycle accept
        a_in_valid = 1'b1; a_sel = 2'd1; a_flush = 1'b1;
        #1;
        chk("flush_in_ready", a_in_ready, 1'b1);
        step();
        chk("flush_valid", a_out_valid, 1'b0);
        chk("flush_data_hold", a_out_data, 32'hC2);
        a_flush = 1'b0; a_sel = 2'd3; step();
        chk("post_flush_data", a_out_data, 32'hD3);
        chk("post_flush_valid", a_out_valid, 1'b1);
        a_in_valid = 1'b0; step();
        chk("drain_valid", a_out_valid, 1'b0);

`ifdef MUX_PIPE_SKID_EN
        // Skid: stalled output holds A0, B1 lands in skid, both delivered in order
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_sel = 2'd0; step();
        chk("skid_out_a0", a_out_data, 32'hA0);
        chk("skid_in_ready_free", a_in_ready, 1'b1);
        a_sel = 2'd1; step();
        chk("skid_in_ready_full", a_in_ready, 1'b0);
        chk("skid_hold_a0", a_out_data, 32'hA0);
        a_in_valid = 1'b0; a_sel = 2'd3; a_out_ready = 1'b1;
        #1;
        chk("skid_first_valid", a_out_valid, 1'b1);
        step();
        chk("skid_second_data", a_out_data, 32'hB1);
        chk("skid_second_valid", a_out_valid, 1'b1);
        chk("skid_in_ready_back", a_in_ready, 1'b1);
        step();
        chk("skid_no_dup", a_out_valid, 1'b0);
`endif

        // Out-of-range select on the 5-lane instance
        b_in_valid = 1'b1; b_sel = 3'd7; step();
        chk("oor_data", b_out_data, 5'h00);
        chk("oor_err", b_sel_err, 1'b1);
        chk("oor_valid", b_out_valid, 1'b1);
        b_sel = 3'd4; step();
        chk("lane4_data", b_out_data, 5'h14);
        chk("lane4_err", b_sel_err, 1'b0);
        b_sel = 3'd5; step();
        chk("oor5_err", b_sel_err, 1'b1);
        b_in_valid = 1'b0; step();
        chk("oor_drain_valid", b_out_valid, 1'b0);
        chk("oor_drain_err", b_sel_err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_pipe_nt1.md
Name: mux_pipe_nt1

Overview:
Parametrised N-input, WIDTH-bit registered multiplexer with a valid/ready handshake on both sides. It is the successor of the 5-bit 2:1 select mux used in the datapath. It serves register-destination, ALU-source and writeback selection where a pipeline register boundary sits directly after the select. It adds stall hold, flush and out-of-range select detection.

Parameters:
WIDTH, 32, data width of each input lane and of out_data
N, 4, number of input lanes (N >= 2)
SEL_W, derived localparam = clog2(N), width of sel; not overridable

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  synchronous reset, active-high
in_data  in  N*WIDTH  packed lanes; lane k = in_data[k*WIDTH +: WIDTH]
sel  in  SEL_W  lane select, sampled on accept
in_valid  in  1  upstream offers data+sel
in_ready  out  1  block can accept this cycle
flush  in  1  discard held output (branch/exception kill)
out_data  out  WIDTH  registered selected lane
out_valid  out  1  out_data is valid
out_ready  in  1  downstream consumes when out_valid
sel_err  out  1  registered; 1 for the item accepted with sel >= N

Behaviour:
- Interface decision: single clock clk; rst is synchronous, active-high.
- Reset (rst=1 at edge): out_valid=0, out_data=0, sel_err=0. in_ready is forced 0 combinationally while rst=1.
- Base mode:
  - in_ready = !rst && (!out_valid || out_ready), combinational.
  - accept = in_valid && in_ready.
- Latency: 1 cycle. Data accepted at edge t appears on out_data with out_valid=1 after edge t.
- Next-state priority, evaluated at each edge:
  1. rst: as above.
  2. flush: out_valid<=0, sel_err<=0, out_data holds. Any concurrent accept is dropped, but in_ready still reports its formula value. Upstream must also treat the item as killed.
  3. accept: out_data<=lane[sel], out_valid<=1, sel_err<=(sel>=N).
  4. out_valid && out_ready, no accept: out_valid<=0, sel_err<=0.
  5. Otherwise hold all outputs (stall: out_valid=1, out_ready=0 keeps out_data stable).
- Out-of-range sel: applies only when N is not a power of two. out_data<=0 and sel_err=1 for that item. sel_err is qualified by out_valid.
- Simultaneous consume and accept: back-to-back throughput of 1 item/cycle, no bubble.
- in_data/sel may change freely when accept=0. Unselected lanes never affect outputs.

Optional Feature:
Macro MUX_PIPE_SKID_EN.
- Defined: a 1-entry skid buffer sits on the input.
  - in_ready becomes a register: in_ready = !skid_valid && !rst.
  - When an accept coincides with a stalled output (out_valid && !out_ready), the item is captured in the skid buffer (data, sel).
  - Skid drains into the output register on the next edge where the output frees; skid has priority over new input.
  - flush clears skid_valid as well.
  - Latency stays 1 cycle when not stalled. Maximum of 2 items in flight. No combinational path from out_ready to in_ready.
- Undefined: base-mode combinational in_ready as above.

Decomposition:
- Shared package mips_mux_pkg holds:
  - clog2 constant function
  - default WIDTH (32) and REGADDR_W (5) constants
  - lane-slice helper macro/function
- One sub-module is natural: mux_skid_buf (WIDTH+SEL_W payload, valid/ready, flush). It is instantiated only under MUX_PIPE_SKID_EN.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1. Required: out_valid=0, out_data=0, sel_err=0, in_ready=0 during reset. After release, in_ready=1.
- Select sweep: N=4, WIDTH=32, lanes {0xA0,0xB1,0xC2,0xD3}, out_ready=1, sel=0..3 on consecutive cycles. Required: out_data 0xA0,0xB1,0xC2,0xD3, one cycle later each, out_valid continuous.
- Stall: accept sel=2 (0xC2), then hold out_ready=0 for 3 cycles while changing lanes. Required: out_data stays 0xC2, in_ready=0 (base mode). Raising out_ready consumes exactly one item.
- Flush: accept sel=1 with flush=1 in the same cycle. Required: out_valid=0 next cycle. Next accept sel=3 → 0xD3 normally.
- Out-of-range: N=5, WIDTH=5, sel=7. Required: out_data=0, sel_err=1, out_valid=1. Next valid sel=4 clears sel_err.
- Skid (MUX_PIPE_SKID_EN): stall output holding 0xA0, accept 0xB1. Required: in_ready drops to 0 next cycle. Releasing out_ready delivers 0xA0 then 0xB1 on consecutive cycles, with no loss or duplicate.
